sbox_share_sched: RTL and testbench
===================================

# sbox_share_sched

Time-multiplexed SubBytes engine and scheduler that shares a reduced bank of `LANES` S-box lookups between two requesters. The two requesters are the round datapath, which needs a 128-bit SubBytes, and the key-expansion path, which needs a 32-bit SubWord. The block sits between the round controller, the key schedule and the S-box bank. It sequences the byte slices through the lanes, arbitrates round-robin between the two requesters, and returns registered results over valid/ready handshakes.

## Interface
- `LANES`, default 4: number of S-box instances; legal values 4, 8, 16; beats per state request `NB = 16/LANES`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `st_req_valid` in 1: state SubBytes request.
- `st_req_ready` out 1: state request accepted on `valid & ready`.
- `st_data_in` in 128: state; byte i = bits [127-8i:120-8i].
- `st_rsp_valid` out 1: state result valid.
- `st_rsp_ready` in 1: state result consumed.
- `st_data_out` out 128: SubBytes(state), same byte ordering.
- `key_req_valid` in 1: SubWord request.
- `key_req_ready` out 1: SubWord request accepted.
- `key_word_in` in 32: word; byte j = bits [31-8j:24-8j].
- `key_rsp_valid` out 1: SubWord result valid.
- `key_rsp_ready` in 1: SubWord result consumed.
- `key_word_out` out 32: SubWord(word).

## Operation
- FSM states: IDLE, ST_BUSY, KEY_BUSY, ST_RESP, KEY_RESP.
- IDLE: `st_req_ready` and `key_req_ready` are 1 only in IDLE and only while `rst` is 0.
- Only one grant per accept edge. If both requests are valid, the grant goes to the requester not served last (`last_grant` flag). After reset, `last_grant` = state, so key wins the first tie.
- Grant with a single valid request: that request is granted regardless of `last_grant`.
- On accept, the input is captured into an internal 128-bit operand register. The requester may change its inputs afterwards.
- On accept, `beat` is cleared. The FSM goes to ST_BUSY or KEY_BUSY and `last_grant` is updated.
- ST_BUSY: each cycle, lanes 0..LANES-1 look up bytes `beat*LANES + l`. Results are written into the result register at the same byte positions and `beat` increments. After beat NB-1 the FSM goes to ST_RESP.
- KEY_BUSY: lanes 0..3 look up the 4 key bytes in one cycle and the result is written to the low 32 bits of the result register. Lanes ≥4 are don't-care. The FSM then goes to KEY_RESP.
- ST_RESP / KEY_RESP: the matching `*_rsp_valid` is 1 and the output is held stable. On `rsp_ready` the FSM returns to IDLE. Results are never dropped.
- `beat` is a `log2(NB)+1`-bit counter. It never wraps inside a request and is cleared on every accept.
- The S-box lookup is combinational (AES forward S-box, FIPS-197). Each lane's address is muxed from the operand register by `beat` and the FSM state.

## Timing
- Reset values: all `*_ready` = 0 while `rst` is high. `*_rsp_valid` = 0, `st_data_out` = 0, `key_word_out` = 0, FSM = IDLE, `beat` = 0, `last_grant` = state.
- State latency: accept at edge E, busy cycles E+1..E+NB, `st_rsp_valid` high from cycle E+NB+1. For LANES=4 this is 5 cycles; for LANES=16 it is 2.
- Key latency: accept at edge E, `key_rsp_valid` high from cycle E+2.
- Response consumed at edge R: IDLE from R+1, so the earliest next accept is at edge R+1. Back-to-back state throughput is one request per NB+2 cycles.
- Reset mid-operation (in any state): the FSM returns to IDLE and no response is issued for the in-flight request. Outputs return to their reset values on the next cycle.
- A request presented while the block is busy stays pending (ready=0) until IDLE. The requester must hold `valid` and its data.

## Configuration
- `SBOX_SHARE_KEY_EN` defined: key port is active as described above.
- `SBOX_SHARE_KEY_EN` undefined:
  - the key path and the KEY_BUSY / KEY_RESP states are compiled out;
  - `key_req_ready`, `key_rsp_valid` and `key_word_out` are tied to 0;
  - the key inputs are ignored and every grant goes to the state requester;
  - state timing is unchanged.

## Test plan
- Reset, then state request `00112233445566778899aabbccddeeff`, LANES=4: `st_data_out` = `638293c31bfc33f5c4eeacea4bc12816`, `st_rsp_valid` 5 cycles after accept.
- Key request `cf4f3c09`: `key_word_out` = `8a84eb01`, valid 2 cycles after accept.
- Both requests valid in the same cycle directly after reset: key granted first and state second. A subsequent tie grants key and state alternately.
- `st_rsp_ready` held 0 for 10 cycles: `st_rsp_valid` and the data stay stable, and a pending key request is not accepted until the state response is consumed.
- `rst` pulsed at the 3rd busy beat of a state request: no `st_rsp_valid` appears, and a new request `000…0` returns `636363…63`.
- Build without `SBOX_SHARE_KEY_EN`, `key_req_valid`=1: `key_req_ready` stays 0 and state requests complete normally.

Source files
------------

// File: rtl/sbox_share_sched.sv
// sbox_share_sched: shares LANES AES S-boxes between a 128-bit SubBytes
// requester and a 32-bit SubWord requester. Requests are granted round-robin
// and each result is returned in a register over a valid/ready handshake.
// Ports: clk, rst (sync, active high);
//   st_req_valid/st_req_ready/st_data_in   state request (128 bit)
//   st_rsp_valid/st_rsp_ready/st_data_out  state result
//   key_req_valid/key_req_ready/key_word_in  SubWord request (32 bit)
//   key_rsp_valid/key_rsp_ready/key_word_out SubWord result
// Macro SBOX_SHARE_KEY_EN enables the key port; when it is undefined the
// key outputs are tied to 0 and the key inputs are ignored.
`timescale 1ns/1ps
module sbox_share_sched #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_data_in,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_data_out,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_word_in,
  output logic         key_rsp_valid,
  input  logic         key_rsp_ready,
  output logic [31:0]  key_word_out
);

  localparam int NB = 16 / LANES;
  localparam int BW = $clog2(NB) + 1;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[(255 - int'(a)) * 8 +: 8];
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    ST_BUSY,
    ST_RESP
`ifdef SBOX_SHARE_KEY_EN
    ,
    KEY_BUSY,
    KEY_RESP
`endif
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [BW-1:0]   beat;
  logic            last_key;
  logic [127:0]    opnd;
  logic [127:0]    res;
  logic            st_acc;
  logic            last_beat;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];
`ifdef SBOX_SHARE_KEY_EN
  logic            key_acc;
  logic            key_win;
`else
  logic            unused_key;
  assign unused_key = ^{key_req_valid, key_rsp_ready, key_word_in};
`endif

  // Lane l serves byte beat*LANES+l of the operand; the key word sits in
  // the low 32 bits and is served by lanes 0..3 in a single beat.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = opnd[8 * (15 - ((int'(beat) * LANES + l) & 15)) +: 8];
`ifdef SBOX_SHARE_KEY_EN
      if (state == KEY_BUSY && l < 4)
        lane_in[l] = opnd[8 * (3 - l) +: 8];
`endif
      lane_out[l] = sbox(lane_in[l]);
    end
  end

  always_comb begin
    state_d       = state;
    st_req_ready  = 1'b0;
    key_req_ready = 1'b0;
    st_acc        = 1'b0;
    last_beat     = (beat == BW'(NB - 1));
`ifdef SBOX_SHARE_KEY_EN
    key_acc       = 1'b0;
    key_win       = 1'b0;
`endif
    unique case (state)
      IDLE: begin
`ifdef SBOX_SHARE_KEY_EN
        // Key wins a tie only when the state side was served last.
        key_win       = key_req_valid & (~st_req_valid | ~last_key);
        st_req_ready  = ~rst & ~key_win;
        key_req_ready = ~rst & ~(st_req_valid & ~key_win);
        key_acc       = key_req_valid & key_req_ready;
        if (key_acc)
          state_d = KEY_BUSY;
`else
        st_req_ready  = ~rst;
`endif
        st_acc = st_req_valid & st_req_ready;
        if (st_acc)
          state_d = ST_BUSY;
      end
      ST_BUSY:
        if (last_beat)
          state_d = ST_RESP;
      ST_RESP:
        if (st_rsp_ready)
          state_d = IDLE;
`ifdef SBOX_SHARE_KEY_EN
      KEY_BUSY:
        state_d = KEY_RESP;
      KEY_RESP:
        if (key_rsp_ready)
          state_d = IDLE;
`endif
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      last_key <= 1'b0;
      opnd     <= '0;
      res      <= '0;
    end else begin
      state <= state_d;
      if (st_acc) begin
        opnd     <= st_data_in;
        beat     <= '0;
        last_key <= 1'b0;
      end
`ifdef SBOX_SHARE_KEY_EN
      if (key_acc) begin
        opnd     <= {96'b0, key_word_in};
        beat     <= '0;
        last_key <= 1'b1;
      end
      if (state == KEY_BUSY) begin
        for (int l = 0; l < 4; l++)
          res[8 * (3 - l) +: 8] <= lane_out[l];
      end
`endif
      if (state == ST_BUSY) begin
        for (int l = 0; l < LANES; l++)
          res[8 * (15 - ((int'(beat) * LANES + l) & 15)) +: 8] <= lane_out[l];
        beat <= beat + 1'b1;
      end
    end
  end

  assign st_rsp_valid = (state == ST_RESP);
  assign st_data_out  = res;
`ifdef SBOX_SHARE_KEY_EN
  assign key_rsp_valid = (state == KEY_RESP);
  assign key_word_out  = res[31:0];
`else
  assign key_rsp_valid = 1'b0;
  assign key_word_out  = 32'b0;
`endif

endmodule

// File: tb/tb_sbox_share_sched.sv
// tb_sbox_share_sched: scoreboard bench for sbox_share_sched.
// Reference S-box is computed from GF(2^8) inversion plus affine map.
`timescale 1ns/1ps
module tb_sbox_share_sched;
  localparam int LANES = 4;
  localparam int NB = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_req_valid = 1'b0;
  logic         st_req_ready;
  logic [127:0] st_data_in = '0;
  logic         st_rsp_valid;
  logic         st_rsp_ready = 1'b0;
  logic [127:0] st_data_out;
  logic         key_req_valid = 1'b0;
  logic         key_req_ready;
  logic [31:0]  key_word_in = '0;
  logic         key_rsp_valid;
  logic         key_rsp_ready = 1'b0;
  logic [31:0]  key_word_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rmode = 0;
  int st_left_at_key = 0;
  bit last_key = 1'b0;

  logic [127:0] st_exp[$];
  int           st_acc[$];
  logic [31:0]  key_exp[$];
  int           key_acc[$];
  bit           st_seen = 1'b0;
  logic [127:0] st_hold = '0;
`ifdef SBOX_SHARE_KEY_EN
  bit           key_seen = 1'b0;
  logic [31:0]  key_hold = '0;
`endif

  sbox_share_sched #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_data_in(st_data_in),
    .st_rsp_valid(st_rsp_valid), .st_rsp_ready(st_rsp_ready),
    .st_data_out(st_data_out),
    .key_req_valid(key_req_valid), .key_req_ready(key_req_ready),
    .key_word_in(key_word_in),
    .key_rsp_valid(key_rsp_valid), .key_rsp_ready(key_rsp_ready),
    .key_word_out(key_word_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Inverse as a^254 (zero maps to zero), then the FIPS-197 affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] x);
    logic [127:0] y = '0;
    for (int i = 0; i < 16; i++)
      y[127 - 8 * i -: 8] = ref_sbox(x[127 - 8 * i -: 8]);
    return y;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] x);
    logic [31:0] y = '0;
    for (int j = 0; j < 4; j++)
      y[31 - 8 * j -: 8] = ref_sbox(x[31 - 8 * j -: 8]);
    return y;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Latency is counted from the accept edge to the first edge that samples
  // the response valid: NB+1 for a state request, 2 for a key request.
  always @(negedge clk) begin
    if (rst) begin
      st_seen = 1'b0;
`ifdef SBOX_SHARE_KEY_EN
      key_seen = 1'b0;
`endif
    end else begin
      if (st_seen) chk("st_valid_held", st_rsp_valid, 1'b1);
      if (st_rsp_valid) begin
        chk("st_rsp_expected", st_exp.size() > 0, 1'b1);
        if (st_exp.size() > 0) begin
          if (!st_seen) begin
            chk("st_latency", cyc - st_acc[0] + 1, NB + 1);
            st_seen = 1'b1;
            st_hold = st_data_out;
          end else begin
            chk("st_hold", st_data_out, st_hold);
          end
          if (st_rsp_ready) begin
            chk("st_data", st_data_out, st_exp[0]);
            void'(st_exp.pop_front());
            void'(st_acc.pop_front());
            st_seen = 1'b0;
          end
        end
      end
`ifdef SBOX_SHARE_KEY_EN
      if (key_seen) chk("key_valid_held", key_rsp_valid, 1'b1);
      if (key_rsp_valid) begin
        chk("key_rsp_expected", key_exp.size() > 0, 1'b1);
        if (key_exp.size() > 0) begin
          if (!key_seen) begin
            chk("key_latency", cyc - key_acc[0] + 1, 2);
            key_seen = 1'b1;
            key_hold = key_word_out;
          end else begin
            chk("key_hold", key_word_out, key_hold);
          end
          if (key_rsp_ready) begin
            chk("key_data", key_word_out, key_exp[0]);
            void'(key_exp.pop_front());
            void'(key_acc.pop_front());
            key_seen = 1'b0;
          end
        end
      end
`else
      if (key_req_valid)
        chk("key_off_out", {key_rsp_valid, key_word_out}, 33'h0);
`endif
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: begin
        st_rsp_ready = 1'b1;
        key_rsp_ready = 1'b1;
      end
      1: begin
        st_rsp_ready = ($urandom % 3) != 0;
        key_rsp_ready = ($urandom % 3) != 0;
      end
      default: begin
        st_rsp_ready = 1'b0;
        key_rsp_ready = 1'b1;
      end
    endcase
  end

  task automatic issue(input bit ds, input bit dk,
                       input logic [127:0] sd, input logic [31:0] kd);
    bit ps = ds;
    bit pk = 1'b0;
    bit gs;
    bit gk;
    int n = 0;
`ifdef SBOX_SHARE_KEY_EN
    pk = dk;
`endif
    @(posedge clk);
    #1;
    st_req_valid = ds;
    st_data_in = sd;
    key_req_valid = dk;
    key_word_in = kd;
    while ((ps || pk) && n < 300) begin
      @(negedge clk);
      n++;
`ifndef SBOX_SHARE_KEY_EN
      if (key_req_valid) chk("key_ready_off", key_req_ready, 1'b0);
`endif
      gs = st_req_valid && st_req_ready;
      gk = key_req_valid && key_req_ready;
      if (gs || gk) begin
        chk("one_grant", gs && gk, 1'b0);
        if (ps && pk) chk("tie_grant_key", gk, !last_key);
        if (gk) begin
          key_exp.push_back(ref_word(kd));
          key_acc.push_back(cyc + 1);
          st_left_at_key = st_exp.size();
          last_key = 1'b1;
          pk = 1'b0;
        end else begin
          st_exp.push_back(ref_sub(sd));
          st_acc.push_back(cyc + 1);
          last_key = 1'b0;
          ps = 1'b0;
        end
        @(posedge clk);
        #1;
        if (gk) begin
          key_req_valid = 1'b0;
          key_word_in = $urandom;
        end else begin
          st_req_valid = 1'b0;
          st_data_in = rnd128();
        end
      end
    end
    chk("accept_timeout", ps || pk, 1'b0);
    st_req_valid = 1'b0;
    key_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((st_exp.size() + key_exp.size()) > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", st_exp.size() + key_exp.size(), 0);
  endtask

  task automatic flush_model();
    st_exp.delete();
    st_acc.delete();
    key_exp.delete();
    key_acc.delete();
    last_key = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    flush_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_st(input string name, input logic [127:0] want);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!st_rsp_valid && n < 50);
    chk(name, st_data_out, want);
  endtask

  initial begin
    rst = 1'b1;
    st_req_valid = 1'b1;
    key_req_valid = 1'b1;
    st_data_in = rnd128();
    key_word_in = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_st_ready", st_req_ready, 1'b0);
    chk("rst_key_ready", key_req_ready, 1'b0);
    chk("rst_st_valid", st_rsp_valid, 1'b0);
    chk("rst_key_valid", key_rsp_valid, 1'b0);
    chk("rst_st_data", st_data_out, 128'h0);
    chk("rst_key_data", key_word_out, 32'h0);
    @(posedge clk);
    #1;
    st_req_valid = 1'b0;
    key_req_valid = 1'b0;
    rst = 1'b0;
    rmode = 0;

    issue(1'b1, 1'b0, 128'h00112233445566778899aabbccddeeff, 32'h0);
    wait_st("vec_state", 128'h638293c31bfc33f5c4eeacea4bc12816);
    drain();
`ifdef SBOX_SHARE_KEY_EN
    issue(1'b0, 1'b1, '0, 32'hcf4f3c09);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!key_rsp_valid && n < 50);
      chk("vec_key", key_word_out, 32'h8a84eb01);
    end
    drain();
`endif

    do_reset();
    for (int i = 0; i < 4; i++)
      issue(1'b1, 1'b1, rnd128(), $urandom);
    drain();

    rmode = 2;
    issue(1'b1, 1'b0, rnd128(), 32'h0);
    @(posedge clk);
    #1;
    key_req_valid = 1'b1;
    key_word_in = $urandom;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("bp_key_blocked", key_req_ready, 1'b0);
      if (i >= 5) chk("bp_st_valid", st_rsp_valid, 1'b1);
    end
    rmode = 0;
`ifdef SBOX_SHARE_KEY_EN
    issue(1'b0, 1'b1, '0, key_word_in);
    chk("key_after_st", st_left_at_key, 0);
`else
    @(posedge clk);
    #1;
    key_req_valid = 1'b0;
`endif
    drain();

    issue(1'b1, 1'b0, rnd128(), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    flush_model();
    @(negedge clk);
    chk("midrst_st_ready", st_req_ready, 1'b0);
    chk("midrst_key_ready", key_req_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_st_valid", st_rsp_valid, 1'b0);
    chk("midrst_st_data", st_data_out, 128'h0);
    repeat (8) @(negedge clk);
    issue(1'b1, 1'b0, 128'h0, 32'h0);
    wait_st("zero_state", {16{8'h63}});
    drain();

    rmode = 1;
    for (int i = 0; i < 60; i++) begin
      bit ds = 1'(($urandom % 2));
      bit dk = 1'(($urandom % 2));
      if (!ds && !dk) ds = 1'b1;
      issue(ds, dk, rnd128(), $urandom);
    end
    rmode = 0;
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
